// File: rtl/text_grid_pkg.sv
// Shared constants and state encoding for the scrolling character-grid store.
package text_grid_pkg;

  localparam logic [7:0] CHAR_BS        = 8'h08;
  localparam logic [7:0] CHAR_LF        = 8'h0A;
  localparam logic [7:0] CHAR_CR        = 8'h0D;
  localparam logic [7:0] CHAR_PRINT_MIN = 8'h20;

  typedef enum logic [1:0] {
    INIT_CLR = 2'd0,
    IDLE     = 2'd1,
    LINE_CLR = 2'd2
  } grid_state_e;

endpackage

// File: rtl/text_grid_buffer_ram.sv
// Flat ROWS*COLS character memory: one synchronous write port, one registered read port.
module grid_ram #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 128,
  parameter int                    AW         = $clog2(DEPTH),
  parameter logic [DATA_WIDTH-1:0] FILL       = DATA_WIDTH'(8'h00)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  input  logic                  rfill,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Write port; the array itself is not reset, the clear FSM initialises it
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read; rfill substitutes the fill value for out-of-range coordinates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_r <= '0;
    end else if (rfill) begin
      rdata_r <= FILL;
    end else begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/text_grid_buffer.sv
// Character grid with cursor, CR/LF/BS handling, wrap, and scrolling via a rotating top-row pointer.
module text_grid_buffer
  import text_grid_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ROWS       = 4,
  parameter int                    COLS       = 32,
  parameter logic [DATA_WIDTH-1:0] FILL_CHAR  = DATA_WIDTH'(8'h00),
  parameter bit                    WRAP_EN    = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_ready,
  input  logic [$clog2(ROWS)-1:0]   r_row,
  input  logic [$clog2(COLS)-1:0]   r_col,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic [$clog2(ROWS)-1:0]   cur_row,
  output logic [$clog2(COLS)-1:0]   cur_col,
  output logic                      busy,
  output logic                      scroll_pulse
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);

  // Logical-to-physical row rotation without assuming a power-of-two row count
  function automatic logic [RW-1:0] phys(input logic [RW-1:0] top, input logic [RW-1:0] r);
    logic [RW:0] s;
    s = {1'b0, top} + {1'b0, r};
    if (s >= (RW+1)'(ROWS)) begin
      s = s - (RW+1)'(ROWS);
    end else begin
      s = s;
    end
    return s[RW-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] row, input logic [CW-1:0] col);
    return AW'(row) * AW'(COLS) + AW'(col);
  endfunction

  grid_state_e           state_r, state_s;
  logic [AW-1:0]         clr_idx_r, clr_idx_s;
  logic [RW-1:0]         cur_row_r, cur_row_s;
  logic [CW-1:0]         cur_col_r, cur_col_s;
  logic [RW-1:0]         top_r, top_s;
  logic [RW-1:0]         clr_row_r, clr_row_s;
  logic                  scroll_r, scroll_s;
  logic                  busy_r, in_ready_r;
  logic                  nl_s, we_s;
  logic [AW-1:0]         waddr_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [AW-1:0]         raddr_s;
  logic                  rfill_s;

  // Next-state, cursor and single write-port arbitration
  always_comb begin
    state_s   = state_r;
    clr_idx_s = clr_idx_r;
    cur_row_s = cur_row_r;
    cur_col_s = cur_col_r;
    top_s     = top_r;
    clr_row_s = clr_row_r;
    scroll_s  = 1'b0;
    nl_s      = 1'b0;
    we_s      = 1'b0;
    waddr_s   = '0;
    wdata_s   = FILL_CHAR;
    case (state_r)
      INIT_CLR: begin
        we_s    = 1'b1;
        waddr_s = clr_idx_r;
        if (clr_idx_r == AW'(DEPTH-1)) begin
          state_s   = IDLE;
          clr_idx_s = '0;
        end else begin
          clr_idx_s = clr_idx_r + AW'(1);
        end
      end
      LINE_CLR: begin
        we_s    = 1'b1;
        waddr_s = cell_addr(clr_row_r, clr_idx_r[CW-1:0]);
        if (clr_idx_r == AW'(COLS-1)) begin
          state_s   = IDLE;
          clr_idx_s = '0;
        end else begin
          clr_idx_s = clr_idx_r + AW'(1);
        end
      end
      IDLE: begin
        if (in_valid) begin
          if (in_data >= DATA_WIDTH'(CHAR_PRINT_MIN)) begin
            we_s    = 1'b1;
            waddr_s = cell_addr(phys(top_r, cur_row_r), cur_col_r);
            wdata_s = in_data;
            if (cur_col_r < CW'(COLS-1)) begin
              cur_col_s = cur_col_r + CW'(1);
            end else if (WRAP_EN) begin
              nl_s = 1'b1;
            end else begin
              cur_col_s = cur_col_r;
            end
          end else if (in_data == DATA_WIDTH'(CHAR_LF)) begin
            nl_s = 1'b1;
          end else if (in_data == DATA_WIDTH'(CHAR_CR)) begin
            cur_col_s = '0;
          end else if (in_data == DATA_WIDTH'(CHAR_BS)) begin
            if (cur_col_r != '0) begin
              cur_col_s = cur_col_r - CW'(1);
              we_s      = 1'b1;
              waddr_s   = cell_addr(phys(top_r, cur_row_r), cur_col_r - CW'(1));
            end else begin
              cur_col_s = cur_col_r;
            end
          end else begin
            nl_s = 1'b0;
          end
        end else begin
          nl_s = 1'b0;
        end
      end
      default: begin
        state_s   = INIT_CLR;
        clr_idx_s = '0;
      end
    endcase

    // Newline at the bottom row scrolls; the row leaving the top is the one to clear
    if (nl_s) begin
      cur_col_s = '0;
      if (cur_row_r < RW'(ROWS-1)) begin
        cur_row_s = cur_row_r + RW'(1);
      end else begin
        top_s     = (top_r == RW'(ROWS-1)) ? '0 : top_r + RW'(1);
        clr_row_s = top_r;
        scroll_s  = 1'b1;
        state_s   = LINE_CLR;
        clr_idx_s = '0;
      end
    end else begin
      scroll_s = scroll_s;
    end
  end

  // Read address decode with out-of-range detection for non-power-of-two sizes
  always_comb begin
    raddr_s = cell_addr(phys(top_r, r_row), r_col);
    rfill_s = ({1'b0, r_row} >= (RW+1)'(ROWS)) || ({1'b0, r_col} >= (CW+1)'(COLS));
  end

  // Control state and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= INIT_CLR;
      clr_idx_r  <= '0;
      cur_row_r  <= '0;
      cur_col_r  <= '0;
      top_r      <= '0;
      clr_row_r  <= '0;
      scroll_r   <= 1'b0;
      busy_r     <= 1'b1;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      clr_idx_r  <= clr_idx_s;
      cur_row_r  <= cur_row_s;
      cur_col_r  <= cur_col_s;
      top_r      <= top_s;
      clr_row_r  <= clr_row_s;
      scroll_r   <= scroll_s;
      busy_r     <= (state_s != IDLE);
      in_ready_r <= (state_s == IDLE);
    end
  end

  grid_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW),
    .FILL       (FILL_CHAR)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr (raddr_s),
    .rfill (rfill_s),
    .rdata (dout)
  );

  assign in_ready     = in_ready_r;
  assign busy         = busy_r;
  assign cur_row      = cur_row_r;
  assign cur_col      = cur_col_r;
  assign scroll_pulse = scroll_r;

endmodule

// File: tb/tb_text_grid_buffer.sv
// Randomised self-checking bench for text_grid_buffer against a shift-register screen model.
module tb_text_grid_buffer;

  localparam int ROWS = 4;
  localparam int COLS = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [1:0] r_row = 2'd0;
  logic [4:0] r_col = 5'd0;
  logic       in_ready, busy, scroll_pulse;
  logic [7:0] dout;
  logic [1:0] cur_row;
  logic [4:0] cur_col;

  int total = 0;
  int bad = 0;
  int sp_cnt = 0;
  int busy_cnt = 0;

  logic [7:0] scr [ROWS][COLS];
  int mrow, mcol, mscrolls;

  text_grid_buffer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .r_row(r_row), .r_col(r_col), .dout(dout), .cur_row(cur_row), .cur_col(cur_col),
    .busy(busy), .scroll_pulse(scroll_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (scroll_pulse) sp_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 8'h00;
    mrow = 0; mcol = 0; mscrolls = 0;
  endtask

  task automatic model_newline();
    mcol = 0;
    if (mrow < ROWS-1) mrow++;
    else begin
      for (int r = 0; r < ROWS-1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h00;
      mscrolls++;
    end
  endtask

  task automatic model_apply(input logic [7:0] b);
    if (b >= 8'h20) begin
      scr[mrow][mcol] = b;
      if (mcol < COLS-1) mcol++;
      else model_newline();
    end else if (b == 8'h0A) model_newline();
    else if (b == 8'h0D) mcol = 0;
    else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        scr[mrow][mcol] = 8'h00;
      end
    end
  endtask

  // Offer a byte (leaves in_valid high); returns on the negedge after acceptance
  task automatic send(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout byte=%h in_ready=%b required=1", b, in_ready);
    end else begin
      @(negedge clk);
      model_apply(b);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic read_cell(input int r, input int c, output logic [7:0] v);
    r_row = 2'(r);
    r_col = 5'(c);
    @(negedge clk);
    v = dout;
  endtask

  task automatic do_reset();
    int t = 0;
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    while (busy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      total++; bad++;
      $display("FAIL init_timeout busy=%b required=0", busy);
    end
    model_clear();
  endtask

  task automatic test_reset();
    int cnt = 0;
    logic [7:0] v;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({busy, in_ready, scroll_pulse, cur_row, cur_col, dout} !== {1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 8'h00}) begin
      bad++;
      $display("FAIL reset_state got busy=%b rdy=%b sp=%b row=%0d col=%0d dout=%h required 1 0 0 0 0 00",
               busy, in_ready, scroll_pulse, cur_row, cur_col, dout);
    end
    @(negedge clk);
    reset = 1'b0;
    while (busy && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    total++;
    if (cnt !== 128) begin bad++; $display("FAIL init_busy_cycles got=%0d required=128", cnt); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL init_ready got=%b required=1", in_ready); end
    model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        read_cell(r, c, v);
        total++;
        if (v !== 8'h00) begin bad++; $display("FAIL init_cell (%0d,%0d) got=%h required=00", r, c, v); end
      end
  endtask

  task automatic test_hi();
    logic [7:0] v;
    do_reset();
    send(8'h48);
    send(8'h69);
    idle(1);
    read_cell(0, 0, v);
    total++;
    if (v !== 8'h48) begin bad++; $display("FAIL hi_cell0 got=%h required=48", v); end
    read_cell(0, 1, v);
    total++;
    if (v !== 8'h69) begin bad++; $display("FAIL hi_cell1 got=%h required=69", v); end
    total++;
    if (cur_col !== 5'd2) begin bad++; $display("FAIL hi_cursor got=%0d required=2", cur_col); end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 33; i++) send(8'h41);
    idle(1);
    for (int c = 0; c < COLS; c++) begin
      read_cell(0, c, v);
      total++;
      if (v !== 8'h41) begin bad++; $display("FAIL wrap_row0 col=%0d got=%h required=41", c, v); end
    end
    read_cell(1, 0, v);
    total++;
    if (v !== 8'h41) begin bad++; $display("FAIL wrap_row1 got=%h required=41", v); end
    total++;
    if (cur_row !== 2'd1 || cur_col !== 5'd1)
      begin bad++; $display("FAIL wrap_cursor got=(%0d,%0d) required=(1,1)", cur_row, cur_col); end
  endtask

  task automatic test_scroll();
    logic [7:0] v;
    do_reset();
    for (int r = 0; r < ROWS; r++) begin
      send(8'h58);
      if (r < ROWS-1) send(8'h0A);
    end
    sp_cnt = 0;
    busy_cnt = 0;
    send(8'h0A);
    send(8'h5A);
    idle(2);
    total++;
    if (sp_cnt !== 1) begin bad++; $display("FAIL scroll_pulses got=%0d required=1", sp_cnt); end
    total++;
    if (busy_cnt !== 32) begin bad++; $display("FAIL scroll_busy got=%0d required=32", busy_cnt); end
    read_cell(0, 0, v);
    total++;
    if (v !== 8'h58) begin bad++; $display("FAIL scroll_top got=%h required=58", v); end
    read_cell(3, 0, v);
    total++;
    if (v !== 8'h5A) begin bad++; $display("FAIL scroll_nolost got=%h required=5a", v); end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        read_cell(r, c, v);
        total++;
        if (v !== scr[r][c]) begin bad++; $display("FAIL scroll_screen (%0d,%0d) got=%h required=%h", r, c, v, scr[r][c]); end
      end
  endtask

  task automatic test_backspace();
    logic [7:0] v;
    do_reset();
    send(8'h41); send(8'h42); send(8'h08); send(8'h08); send(8'h08);
    idle(1);
    total++;
    if (cur_row !== 2'd0 || cur_col !== 5'd0)
      begin bad++; $display("FAIL bs_cursor got=(%0d,%0d) required=(0,0)", cur_row, cur_col); end
    read_cell(0, 0, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL bs_cell0 got=%h required=00", v); end
    read_cell(0, 1, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL bs_cell1 got=%h required=00", v); end
  endtask

  task automatic test_random();
    logic [7:0] v, b;
    int k;
    do_reset();
    sp_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      if (k <= 5) b = 8'($urandom_range(8'h20, 8'h7E));
      else if (k == 6) b = 8'h0A;
      else if (k == 7) b = 8'h0D;
      else if (k == 8) b = 8'h08;
      else b = 8'($urandom_range(0, 31));
      send(b);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);
    total++;
    if (cur_row !== 2'(mrow) || cur_col !== 5'(mcol))
      begin bad++; $display("FAIL rand_cursor got=(%0d,%0d) required=(%0d,%0d)", cur_row, cur_col, mrow, mcol); end
    total++;
    if (sp_cnt !== mscrolls) begin bad++; $display("FAIL rand_scrolls got=%0d required=%0d", sp_cnt, mscrolls); end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        read_cell(r, c, v);
        total++;
        if (v !== scr[r][c]) begin bad++; $display("FAIL rand_screen (%0d,%0d) got=%h required=%h", r, c, v, scr[r][c]); end
      end
  endtask

  task automatic test_reset_midclear();
    logic [7:0] v;
    int cnt = 0;
    do_reset();
    send(8'h51);
    for (int i = 0; i < ROWS-1; i++) send(8'h0A);
    send(8'h52);
    send(8'h0A);
    in_valid = 1'b0;
    r_row = 2'd2;
    r_col = 5'd0;
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b1 || dout !== 8'h52 || cur_row !== 2'd3)
      begin bad++; $display("FAIL midclr_pre got busy=%b dout=%h row=%0d required 1 52 3", busy, dout, cur_row); end
    reset = 1'b1;
    #1;
    total++;
    if ({busy, in_ready, scroll_pulse, cur_row, cur_col, dout} !== {1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 8'h00}) begin
      bad++;
      $display("FAIL midclr_reset got busy=%b rdy=%b sp=%b row=%0d col=%0d dout=%h required 1 0 0 0 0 00",
               busy, in_ready, scroll_pulse, cur_row, cur_col, dout);
    end
    @(negedge clk);
    reset = 1'b0;
    while (busy && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    total++;
    if (cnt !== 128) begin bad++; $display("FAIL midclr_reinit got=%0d required=128", cnt); end
    model_clear();
    read_cell(2, 0, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL midclr_cleared got=%h required=00", v); end
  endtask

  initial begin
    test_reset();
    test_hi();
    test_wrap();
    test_scroll();
    test_backspace();
    test_random();
    test_reset_midclear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_grid_buffer.md
Name: text_grid_buffer

Overview:
- Parametrised character-grid store; the successor of the fixed 2D dual-port character RAM.
- Accepts a byte stream over a valid/ready handshake and maintains its own cursor.
- Interprets CR, LF and BS, wraps long lines, and scrolls by rotating a top-row pointer, then clears the exposed line in hardware.
- Sits between the UART/keyboard byte source and the display/readout logic, which reads logical (scrolled) coordinates through a registered read port.

Parameters:
- DATA_WIDTH, 8, character width in bits (must be >= 8).
- ROWS, 4, number of text rows (>= 2, any integer).
- COLS, 32, number of columns (>= 2, any integer).
- FILL_CHAR, 8'h00, value written by initial clear, line clear and backspace.
- WRAP_EN, 1, 1 = auto-wrap at end of line; 0 = clamp, overwrite the last column.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  a byte is offered on in_data.
- in_data  input  DATA_WIDTH  character or control code.
- in_ready  output  1  block accepts in_data this cycle.
- r_row  input  $clog2(ROWS)  logical read row (0 = top visible line).
- r_col  input  $clog2(COLS)  read column.
- dout  output  DATA_WIDTH  registered read data.
- cur_row  output  $clog2(ROWS)  logical cursor row.
- cur_col  output  $clog2(COLS)  cursor column.
- busy  output  1  a clear is in progress.
- scroll_pulse  output  1  one-cycle pulse on each scroll.

Behaviour:
- Reset (async assert, sync release):
  - dout=0, cur_row=0, cur_col=0, top_ptr=0, scroll_pulse=0.
  - State goes to INIT_CLR, so busy=1 and in_ready=0.
- INIT_CLR:
  - Writes FILL_CHAR to one cell per cycle, linear order, ROWS*COLS cycles.
  - Then goes to IDLE; busy falls and in_ready rises in the same cycle.
- IDLE: in_ready=1. A byte is consumed when in_valid&&in_ready.
- Printable (>=0x20):
  - mem[phys(cur_row)][cur_col] <= in_data.
  - If cur_col<COLS-1: cur_col++.
  - Else if WRAP_EN: perform a newline. If !WRAP_EN: cursor stays put.
- LF 0x0A: newline, defined as cur_col=0 and then:
  - if cur_row<ROWS-1, cur_row++;
  - else scroll (below).
- CR 0x0D: cur_col=0, no write.
- BS 0x08:
  - if cur_col>0, cur_col-- and write FILL_CHAR at the new position;
  - at cur_col==0, no-op (no reverse wrap).
- Other codes <0x20 are consumed and dropped; no write, no cursor change.
- Scroll:
  - top_ptr <= (top_ptr+1) mod ROWS; cur_row stays ROWS-1.
  - scroll_pulse=1 for exactly that cycle.
  - State goes to LINE_CLR.
- LINE_CLR:
  - Writes FILL_CHAR to physical row (new top_ptr+ROWS-1) mod ROWS, columns 0..COLS-1, one per cycle, COLS cycles.
  - busy=1, in_ready=0 throughout. Returns to IDLE after the last column.
- Mapping: phys(r) = (top_ptr + r) mod ROWS, computed with compare-and-subtract. It must not assume ROWS is a power of two.
- Read port:
  - dout <= mem[phys(r_row)][r_col] every cycle, independent of state; latency 1.
  - Same-cycle read/write to the same cell returns the old data.
  - Reads during a clear are legal.
- Out-of-range r_col or r_row (non-power-of-two dims): dout=FILL_CHAR.
- Only one write per cycle. Input bytes are never lost: the handshake stalls the source during clears.
- Reset mid-clear or mid-stream aborts immediately and restarts INIT_CLR after release.

Decomposition:
- Package text_grid_pkg holds:
  - control-code constants (CHAR_CR=0x0D, CHAR_LF=0x0A, CHAR_BS=0x08, CHAR_PRINT_MIN=0x20);
  - the state enum {INIT_CLR, IDLE, LINE_CLR}.
- One sub-module, grid_ram: a simple ROWS*COLS x DATA_WIDTH memory with one synchronous write port and one registered read port, flat address row*COLS+col.
- Cursor, scroll logic and FSM stay in text_grid_buffer.

Test Plan:
- Reset, then hold in_valid=0:
  - busy=1 for exactly 128 cycles (4x32);
  - in_ready rises on cycle 128;
  - every cell reads 0x00.
- Send 'H','i' (0x48, 0x69):
  - read (0,0)=0x48 and (0,1)=0x69, one cycle after the address is applied;
  - cur_col=2.
- Send 33 printable 'A's with WRAP_EN=1:
  - row 0 is 32x 0x41;
  - (1,0)=0x41;
  - cursor (1,1).
- Write 'X' on rows 0..3, then LF at row 3:
  - scroll_pulse once, busy for 32 cycles;
  - logical row 0 now holds the old row 1 'X';
  - row 3 is all 0x00;
  - in_valid held high throughout, so no byte is lost.
- Send 'A','B',BS,BS,BS:
  - cursor ends at (0,0);
  - (0,0)=0x00 and (0,1)=0x00;
  - the third BS is a no-op.
- Assert reset during LINE_CLR:
  - outputs return to reset values asynchronously;
  - after release, the full INIT_CLR of 128 cycles reruns.
